// File: rtl/bank_accounter.sv
// ---------------------------------------------------------------------------
// bank_accounter
//
// Tracks which BRAM bank holds the latest copy of every address. Each write
// agent owns one bank. When an agent writes address A, the table entry for A
// records that agent's bank index. When several agents hit the same address
// in one cycle, the highest agent index wins and, optionally, the entry is
// flagged as a write collision. Read agents look the table up combinationally
// and get the bank index (plus flag) to steer their data muxes.
//
// Ports
//   aclk            : clock, rising edge
//   aresetn         : asynchronous active-low reset
//   wren            : per-write-agent write enable
//   wraddr          : per-write-agent address, agent w at [ADDR_WIDTH*w +: ADDR_WIDTH]
//   rden            : per-read-agent read enable
//   rdaddr          : per-read-agent address, same packing as wraddr
//   bank_select     : per-read-agent {collision flag, bank index}, zero when not reading
//   collision_count : saturating count of cycles that saw at least one collision
// ---------------------------------------------------------------------------
module bank_accounter #(
   parameter int ADDR_WIDTH      = 8,
   parameter int NB_WRAGENT      = 2,
   parameter int NB_RDAGENT      = 2,
   parameter int WRITE_COLLISION = 1,
   parameter int SELECT_WIDTH    = ((NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [NB_WRAGENT-1:0]            wren,
   input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
   input  logic [NB_RDAGENT-1:0]            rden,
   input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
   output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
   output logic [15:0]                      collision_count
);

   localparam int IDX_WIDTH = SELECT_WIDTH - WRITE_COLLISION;
   localparam int DEPTH     = 2**ADDR_WIDTH;

   logic [SELECT_WIDTH-1:0] entry_q  [DEPTH];
   logic [SELECT_WIDTH-1:0] wr_entry [NB_WRAGENT];
   logic [NB_WRAGENT-1:0]   wr_shared;
   logic                    any_collision;

   // For every active writer, find out whether some other active writer is
   // hitting the same address this cycle. The highest colliding agent is the
   // one whose value lands in the table, and it carries this flag with it.
   always_comb begin
      wr_shared = '0;
      for (int w = 0; w < NB_WRAGENT; w++) begin
         for (int v = 0; v < NB_WRAGENT; v++) begin
            if ((v != w) && wren[w] && wren[v] &&
                (wraddr[ADDR_WIDTH*w +: ADDR_WIDTH] == wraddr[ADDR_WIDTH*v +: ADDR_WIDTH])) begin
               wr_shared[w] = 1'b1;
            end
         end
      end
   end

   assign any_collision = (WRITE_COLLISION != 0) && (|wr_shared);

   // Build the value each agent would store: its own bank index, and the
   // collision flag on top when the flag is part of the entry.
   generate
      if (WRITE_COLLISION != 0) begin : g_flagged
         always_comb begin
            for (int w = 0; w < NB_WRAGENT; w++) begin
               wr_entry[w] = {wr_shared[w], IDX_WIDTH'(w)};
            end
         end
      end else begin : g_plain
         always_comb begin
            for (int w = 0; w < NB_WRAGENT; w++) begin
               wr_entry[w] = SELECT_WIDTH'(w);
            end
         end
      end
   endgenerate

   // The table itself. Agents are applied in ascending order so that when
   // several agents target one address the last (highest) assignment wins.
   // Distinct addresses are simply independent writes in the same cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int a = 0; a < DEPTH; a++) begin
            entry_q[a] <= '0;
         end
      end else begin
         for (int w = 0; w < NB_WRAGENT; w++) begin
            if (wren[w]) begin
               entry_q[wraddr[ADDR_WIDTH*w +: ADDR_WIDTH]] <= wr_entry[w];
            end
         end
      end
   end

   // One increment per cycle that saw any collision, however many addresses
   // collided, and the counter sticks at all-ones instead of wrapping.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         collision_count <= '0;
      end else if (any_collision && (collision_count != 16'hFFFF)) begin
         collision_count <= collision_count + 16'd1;
      end
   end

   // Lookups read the registered table, so a same-cycle write is not yet
   // visible: this mirrors the old-data behaviour of the BRAM banks. Disabled
   // readers and the reset period both present all zeros.
   always_comb begin
      bank_select = '0;
      for (int r = 0; r < NB_RDAGENT; r++) begin
         if (aresetn && rden[r]) begin
            bank_select[SELECT_WIDTH*r +: SELECT_WIDTH] = entry_q[rdaddr[ADDR_WIDTH*r +: ADDR_WIDTH]];
         end
      end
   end

endmodule

// File: tb/tb_bank_accounter.sv
// ---------------------------------------------------------------------------
// tb_bank_accounter
//
// Drives bank_accounter with directed scenarios followed by random traffic,
// and keeps its own picture of the table (who last wrote each address and
// whether that write collided) plus the collision counter. Every cycle the
// DUT outputs are compared to what that picture says they must be.
// ---------------------------------------------------------------------------
module tb_bank_accounter;

   localparam int AW = 8;
   localparam int NW = 2;
   localparam int NR = 2;
   localparam int SW = 2;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic [NW-1:0]    wren;
   logic [NW*AW-1:0] wraddr;
   logic [NR-1:0]    rden;
   logic [NR*AW-1:0] rdaddr;
   logic [NR*SW-1:0] bank_select;
   logic [15:0]      collision_count;

   int compared   = 0;
   int mismatched = 0;

   int m_idx  [256];
   int m_flag [256];
   int m_count;

   logic [NR*SW-1:0] last_sel;
   logic [15:0]      last_cnt;
   logic [NR*SW-1:0] or_sel;
   logic [7:0]       ra;

   bank_accounter #(
      .ADDR_WIDTH(AW),
      .NB_WRAGENT(NW),
      .NB_RDAGENT(NR),
      .WRITE_COLLISION(1)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .wren(wren),
      .wraddr(wraddr),
      .rden(rden),
      .rdaddr(rdaddr),
      .bank_select(bank_select),
      .collision_count(collision_count)
   );

   // Free-running clock, period 10.
   always #5 aclk = ~aclk;

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected to be done", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic clearModel();
      for (int a = 0; a < 256; a++) begin
         m_idx[a]  = 0;
         m_flag[a] = 0;
      end
      m_count = 0;
   endtask

   // Expected outputs come straight from the model table as it stood before
   // this cycle's writes: readers see old data.
   task automatic checkOutput();
      logic [NR*SW-1:0] exp_sel;
      int a;
      exp_sel = '0;
      for (int r = 0; r < NR; r++) begin
         if (aresetn && rden[r]) begin
            a = int'(rdaddr[AW*r +: AW]);
            exp_sel[SW*r]     = (m_idx[a] != 0);
            exp_sel[SW*r + 1] = (m_flag[a] != 0);
         end
      end
      last_sel = bank_select;
      last_cnt = collision_count;
      compareVal("bank_select", 32'(last_sel), 32'(exp_sel));
      compareVal("collision_count", 32'(last_cnt), 32'(m_count));
   endtask

   // Apply one clock edge to the model: group this cycle's writers by
   // address, the highest agent per address wins, more than one writer on an
   // address means a collision, and any collision bumps the counter once.
   task automatic updateModel();
      int hits [int];
      int top  [int];
      bit coll;
      int a;
      coll = 1'b0;
      if (!aresetn) return;
      for (int w = 0; w < NW; w++) begin
         if (wren[w]) begin
            a = int'(wraddr[AW*w +: AW]);
            if (hits.exists(a)) hits[a] = hits[a] + 1;
            else hits[a] = 1;
            top[a] = w;
         end
      end
      foreach (hits[k]) begin
         m_idx[k]  = top[k];
         m_flag[k] = (hits[k] > 1) ? 1 : 0;
         if (hits[k] > 1) coll = 1'b1;
      end
      if (coll && (m_count < 65535)) m_count++;
   endtask

   // One full cycle: drive inputs, check outputs mid-cycle, then let the
   // edge happen in both DUT and model. Entered and left 2 units after a
   // rising edge.
   task automatic applyStimulus(input logic [1:0] we, input logic [7:0] wa0, input logic [7:0] wa1,
                                input logic [1:0] re, input logic [7:0] ra0, input logic [7:0] ra1);
      wren   = we;
      wraddr = {wa1, wa0};
      rden   = re;
      rdaddr = {ra1, ra0};
      @(negedge aclk);
      checkOutput();
      @(posedge aclk);
      updateModel();
      #2;
   endtask

   task automatic setReset(input logic v);
      aresetn = v;
      if (!v) clearModel();
   endtask

   initial begin
      logic [7:0] x;
      logic [7:0] y;
      wren    = '0;
      wraddr  = '0;
      rden    = '0;
      rdaddr  = '0;
      aresetn = 1'b0;
      clearModel();

      // Reset held: writes are dropped and reads give zero even when enabled.
      applyStimulus(2'b11, 8'h05, 8'h05, 2'b11, 8'h05, 8'h00);
      applyStimulus(2'b11, 8'h05, 8'h05, 2'b11, 8'h05, 8'h00);
      compareVal("reset_sel", 32'(last_sel), 32'h0);
      compareVal("reset_cnt", 32'(last_cnt), 32'h0);
      setReset(1'b1);

      // Single writer: agent1 writes 0x10.
      applyStimulus(2'b10, 8'h00, 8'h10, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 8'h10, 8'h00);
      compareVal("single_writer", 32'(last_sel[1:0]), 32'h1);
      compareVal("model_single_writer", 32'(m_flag[16] * 2 + m_idx[16]), 32'h1);

      // Same-address collision at 0x20.
      applyStimulus(2'b11, 8'h20, 8'h20, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 8'h20, 8'h00);
      compareVal("collision_sel", 32'(last_sel[1:0]), 32'h3);
      compareVal("collision_cnt", 32'(last_cnt), 32'h1);
      compareVal("model_collision_cnt", 32'(m_count), 32'h1);

      // Agent0 alone rewrites 0x20: flag clears, count unchanged.
      applyStimulus(2'b01, 8'h20, 8'h00, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 8'h20, 8'h00);
      compareVal("collision_clear_sel", 32'(last_sel[1:0]), 32'h0);
      compareVal("collision_clear_cnt", 32'(last_cnt), 32'h1);

      // Read and write of 0x30 in the same cycle returns the old entry.
      applyStimulus(2'b10, 8'h00, 8'h30, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b01, 8'h30, 8'h00, 2'b01, 8'h30, 8'h00);
      compareVal("rbw_same_cycle", 32'(last_sel[1:0]), 32'h1);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 8'h30, 8'h00);
      compareVal("rbw_next_cycle", 32'(last_sel[1:0]), 32'h0);

      // Distinct addresses in one cycle, then a disabled reader.
      applyStimulus(2'b11, 8'h01, 8'h02, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b11, 8'h01, 8'h02);
      compareVal("distinct_sel", 32'(last_sel), 32'h4);
      compareVal("distinct_cnt", 32'(last_cnt), 32'h1);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b10, 8'h02, 8'h02);
      compareVal("rden_off_sel", 32'(last_sel), 32'h4);

      // A write coinciding with reset is lost; writes resume on the first
      // edge after release.
      setReset(1'b0);
      applyStimulus(2'b10, 8'h00, 8'h40, 2'b00, 8'h00, 8'h00);
      setReset(1'b1);
      applyStimulus(2'b10, 8'h00, 8'h41, 2'b11, 8'h40, 8'h10);
      compareVal("reset_write_lost", 32'(last_sel), 32'h0);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b11, 8'h41, 8'h40);
      compareVal("write_after_release", 32'(last_sel), 32'h1);

      // Random traffic over a small address window so collisions and
      // read/write overlaps happen often, with the odd reset pulse.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) setReset(1'b0);
         else if (!aresetn) setReset(1'b1);
         applyStimulus(2'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                       2'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
      end
      setReset(1'b1);

      // Drive the counter into saturation.
      for (int i = 0; i < 65537; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         applyStimulus(2'b11, x, x, 2'($urandom), y, x);
      end
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
      compareVal("saturated_cnt", 32'(last_cnt), 32'hFFFF);
      compareVal("model_saturated_cnt", 32'(m_count), 32'hFFFF);
      applyStimulus(2'b11, 8'h77, 8'h77, 2'b00, 8'h00, 8'h00);
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 8'h77, 8'h00);
      compareVal("saturated_hold", 32'(last_cnt), 32'hFFFF);
      compareVal("saturated_entry", 32'(last_sel[1:0]), 32'h3);

      // Mid-run reset wipes the count and every entry.
      setReset(1'b0);
      applyStimulus(2'b11, 8'h77, 8'h77, 2'b11, 8'h77, 8'h77);
      compareVal("midrun_reset_cnt", 32'(last_cnt), 32'h0);
      setReset(1'b1);
      or_sel = '0;
      for (int a = 0; a < 128; a++) begin
         ra = 8'(a);
         applyStimulus(2'b00, 8'h00, 8'h00, 2'b11, ra, ra + 8'd128);
         or_sel = or_sel | last_sel;
      end
      compareVal("post_reset_all_zero", 32'(or_sel), 32'h0);
      compareVal("post_reset_cnt", 32'(last_cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bank_accounter.md
BANK_ACCOUNTER -- requirements
Module: bank_accounter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: write/read address width; table depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter NB_WRAGENT, default 2: number of write agents, which equals the number of BRAM banks.
REQ-003 SHALL have parameter NB_RDAGENT, default 2: number of read agents (1..4).
REQ-004 SHALL have parameter WRITE_COLLISION, default 1: when 1, a collision flag is stored and reported.
REQ-005 SHALL have parameter SELECT_WIDTH, default (NB_WRAGENT==1 ? 1 : clog2(NB_WRAGENT)) + WRITE_COLLISION: width of one bank_select field.
REQ-006 SHALL define IDX_WIDTH = SELECT_WIDTH - WRITE_COLLISION as the bank-index field width.
REQ-007 SHALL have port aclk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port wren, input, NB_WRAGENT bits: per-write-agent write enable.
REQ-010 SHALL have port wraddr, input, NB_WRAGENT*ADDR_WIDTH bits: per-write-agent address, agent w at [ADDR_WIDTH*w +: ADDR_WIDTH].
REQ-011 SHALL have port rden, input, NB_RDAGENT bits: per-read-agent read enable.
REQ-012 SHALL have port rdaddr, input, NB_RDAGENT*ADDR_WIDTH bits: per-read-agent address, same packing as wraddr.
REQ-013 SHALL have port bank_select, output, NB_RDAGENT*SELECT_WIDTH bits: per-read-agent bank selector; agent r at [SELECT_WIDTH*r +: SELECT_WIDTH]; bits [IDX_WIDTH-1:0] = bank index; MSB = write-collision flag when WRITE_COLLISION=1.
REQ-014 SHALL have port collision_count, output, 16 bits: saturating count of write-collision events.

Function
REQ-015 SHALL hold a table of 2**ADDR_WIDTH entries, each entry = bank index (IDX_WIDTH bits) plus, if WRITE_COLLISION=1, a collision flag (1 bit).
REQ-016 SHALL, on each rising edge where exactly one write agent w has wren[w]=1 for address A, set entry[A] to {flag=0, index=w}.
REQ-017 SHALL, when two or more write agents assert wren for the same address A in the same cycle, set entry[A].index to the highest such agent index.
REQ-018 SHALL also, in the REQ-017 case, set entry[A].flag to 1 when WRITE_COLLISION=1.
REQ-019 SHALL update distinct addresses written in the same cycle independently and all in that cycle.
REQ-020 SHALL drive bank_select for read agent r combinationally as entry[rdaddr_r] when rden[r]=1, and as all zeros when rden[r]=0.
REQ-021 SHALL apply read-before-write semantics: a read and a write to the same address in the same cycle return the pre-write entry, matching BRAM old-data behaviour; the new value is visible from the next cycle.
REQ-022 SHALL let multiple read agents look up the same or different addresses concurrently with no arbitration and no stall.
REQ-023 SHALL increment collision_count by 1 per rising edge where at least one address sees a REQ-017 collision; multiple colliding addresses in one cycle count as 1.
REQ-024 SHALL saturate collision_count at 16'hFFFF without wrapping.
REQ-025 SHALL keep collision_count at 0 permanently when WRITE_COLLISION=0.
REQ-026 SHALL, when NB_WRAGENT==1, store index 0 on every write and never flag a collision.
REQ-027 SHALL ignore a write agent's wraddr whenever its wren=0.
REQ-028 SHALL have no handshake back-pressure: every write is accepted in its cycle.

Reset
REQ-029 SHALL, while aresetn=0, clear every table entry to index 0 and flag 0.
REQ-030 SHALL, while aresetn=0, clear collision_count to 0.
REQ-031 SHALL drive bank_select to all zeros while aresetn=0, independent of rden.
REQ-032 SHALL discard a write coinciding with reset assertion.
REQ-033 SHALL accept writes from the first rising edge after aresetn deasserts.
REQ-034 SHALL, on reset asserted mid-operation, discard all prior entries and all accumulated collision counts.

Verification (defaults: NB_WRAGENT=2, NB_RDAGENT=2, ADDR_WIDTH=8, WRITE_COLLISION=1)
REQ-035 SHALL cover the single-writer scenario: agent1 writes 0x10 -> next cycle, rden[0]=1 with rdaddr 0x10 gives bank_select[1:0]=2'b01 (flag 0, index 1).
REQ-036 SHALL cover the same-address collision scenario: agents 0 and 1 write 0x20 in the same cycle -> read of 0x20 gives 2'b11; collision_count=1.
REQ-037 SHALL cover collision clearing: after REQ-036, agent0 alone writes 0x20 -> read gives 2'b00; collision_count stays 1.
REQ-038 SHALL cover same-cycle read/write: agent1 wrote 0x30 earlier, then in one cycle agent0 writes 0x30 and agent0 reads 0x30 -> that cycle returns 2'b01; the following cycle returns 2'b00.
REQ-039 SHALL cover distinct addresses plus disabled read: agent0 writes 0x01 and agent1 writes 0x02 in one cycle -> reads give 2'b00 and 2'b01; collision_count unchanged; rden[r]=0 forces that agent's bank_select field to 0.
REQ-040 SHALL cover saturation and reset: 65537 collision cycles -> collision_count=16'hFFFF; assert aresetn=0 mid-run -> count 0 and all entries read 2'b00 after release.
